// File: rtl/map_tile_server.sv
// map_tile_server: tile map store for a maze game. On reset the map is
// rebuilt one tile per cycle (walls on the border, big blobs near the four
// corners, small dots elsewhere). After that, single-outstanding read and
// write requests are served. The server keeps a running count of tiles that
// still hold a pellet (big blob or small dot).
module map_tile_server #(
  parameter int MAP_W = 21,
  parameter int MAP_H = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       readwrite,
  input  logic [4:0] map_x,
  input  logic [4:0] map_y,
  input  logic [2:0] wr_data,
  output logic [2:0] rd_data,
  output logic       rd_valid,
  output logic       wr_done,
  output logic       init_done,
  output logic [9:0] pellet_count,
  output logic       all_eaten
);

  localparam int DEPTH  = MAP_W * MAP_H;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] CODE_BLOB = 3'b001;
  localparam logic [2:0] CODE_DOT  = 3'b010;
  localparam logic [2:0] CODE_WALL = 3'b011;

  localparam logic [9:0]        COUNT_MAX = 10'd1023;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [4:0]        X_LAST    = 5'(MAP_W - 1);
  localparam logic [4:0]        Y_LAST    = 5'(MAP_H - 1);
  localparam logic [4:0]        X_INNER   = 5'(MAP_W - 2);
  localparam logic [4:0]        Y_INNER   = 5'(MAP_H - 2);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_READ      = 3'd2,
    S_WR_CHECK  = 3'd3,
    S_WR_COMMIT = 3'd4
  } state_t;

  // Big blobs and small dots are the only codes that count as pellets.
  function automatic logic is_pellet(input logic [2:0] code);
    return (code == CODE_BLOB) || (code == CODE_DOT);
  endfunction

  // Saturating pellet counter steps.
  function automatic logic [9:0] count_inc(input logic [9:0] cnt);
    return (cnt == COUNT_MAX) ? cnt : cnt + 10'd1;
  endfunction

  function automatic logic [9:0] count_dec(input logic [9:0] cnt);
    return (cnt == 10'd0) ? cnt : cnt - 10'd1;
  endfunction

  logic [2:0]        mem [0:DEPTH-1];
  state_t            state_r;
  logic [ADDR_W-1:0] init_addr_r;
  logic [4:0]        init_x_r;
  logic [4:0]        init_y_r;
  logic [ADDR_W-1:0] addr_r;
  logic              oor_r;
  logic [2:0]        wr_data_r;
  logic [2:0]        ram_q_r;
  logic              read_pend_r;
  logic              req_ready_r;
  logic              rd_valid_r;
  logic              wr_done_r;
  logic              init_done_r;
  logic [2:0]        rd_data_r;
  logic [9:0]        pellet_count_r;

  logic              req_oor_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic [2:0]        init_code_s;
  logic              commit_ok_s;
  logic [9:0]        count_next_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [2:0]        wdata_s;

  // Decode the incoming coordinates; out-of-range requests use address 0.
  always_comb begin
    req_oor_s  = ({1'b0, map_x} >= 6'(MAP_W)) || ({1'b0, map_y} >= 6'(MAP_H));
    req_addr_s = ADDR_ZERO;
    if (req_oor_s) begin
      req_addr_s = ADDR_ZERO;
    end else begin
      req_addr_s = ADDR_W'(map_y) * ADDR_W'(MAP_W) + ADDR_W'(map_x);
    end
  end

  // Initial sprite for the tile currently being initialised.
  always_comb begin
    init_code_s = CODE_DOT;
    if (init_x_r == 5'd0 || init_x_r == X_LAST || init_y_r == 5'd0 || init_y_r == Y_LAST) begin
      init_code_s = CODE_WALL;
    end else if ((init_x_r == 5'd1 || init_x_r == X_INNER) &&
                 (init_y_r == 5'd1 || init_y_r == Y_INNER)) begin
      init_code_s = CODE_BLOB;
    end else begin
      init_code_s = CODE_DOT;
    end
  end

  // A write lands only on an in-range tile that is not a wall; count follows the pellet transition.
  always_comb begin
    commit_ok_s  = !oor_r && (ram_q_r != CODE_WALL);
    count_next_s = pellet_count_r;
    if (!commit_ok_s) begin
      count_next_s = pellet_count_r;
    end else if (is_pellet(ram_q_r) && !is_pellet(wr_data_r)) begin
      count_next_s = count_dec(pellet_count_r);
    end else if (!is_pellet(ram_q_r) && is_pellet(wr_data_r)) begin
      count_next_s = count_inc(pellet_count_r);
    end else begin
      count_next_s = pellet_count_r;
    end
  end

  // Single RAM write port shared by initialisation and write commits.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = init_addr_r;
    wdata_s = init_code_s;
    if (reset) begin
      we_s = 1'b0;
    end else if (state_r == S_INIT) begin
      we_s = 1'b1;
    end else if (state_r == S_WR_COMMIT && commit_ok_s) begin
      we_s    = 1'b1;
      waddr_s = addr_r;
      wdata_s = wr_data_r;
    end else begin
      we_s = 1'b0;
    end
  end

  // Tile RAM with a registered read of the captured request address.
  always_ff @(posedge clock) begin
    if (we_s) begin
      mem[waddr_s] <= wdata_s;
    end
    ram_q_r <= mem[addr_r];
  end

  // Control FSM: init sweep, request acceptance, read return and write commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= S_INIT;
      init_addr_r    <= ADDR_ZERO;
      init_x_r       <= 5'd0;
      init_y_r       <= 5'd0;
      addr_r         <= ADDR_ZERO;
      oor_r          <= 1'b0;
      wr_data_r      <= 3'b000;
      read_pend_r    <= 1'b0;
      req_ready_r    <= 1'b0;
      rd_valid_r     <= 1'b0;
      wr_done_r      <= 1'b0;
      init_done_r    <= 1'b0;
      rd_data_r      <= 3'b000;
      pellet_count_r <= 10'd0;
    end else begin
      rd_valid_r <= 1'b0;
      wr_done_r  <= 1'b0;
      // The read data fetched by S_READ is returned one cycle later, overlapping the next request.
      if (read_pend_r) begin
        rd_data_r   <= oor_r ? CODE_WALL : ram_q_r;
        rd_valid_r  <= 1'b1;
        read_pend_r <= 1'b0;
      end
      case (state_r)
        S_INIT: begin
          if (is_pellet(init_code_s)) begin
            pellet_count_r <= count_inc(pellet_count_r);
          end
          if (init_addr_r == ADDR_LAST) begin
            state_r     <= S_IDLE;
            init_done_r <= 1'b1;
            req_ready_r <= 1'b1;
          end else begin
            init_addr_r <= init_addr_r + ADDR_ONE;
            if (init_x_r == X_LAST) begin
              init_x_r <= 5'd0;
              init_y_r <= init_y_r + 5'd1;
            end else begin
              init_x_r <= init_x_r + 5'd1;
            end
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            addr_r      <= req_addr_s;
            oor_r       <= req_oor_s;
            wr_data_r   <= wr_data;
            req_ready_r <= 1'b0;
            state_r     <= readwrite ? S_WR_CHECK : S_READ;
          end
        end
        S_READ: begin
          read_pend_r <= 1'b1;
          req_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
        S_WR_CHECK: begin
          state_r <= S_WR_COMMIT;
        end
        S_WR_COMMIT: begin
          pellet_count_r <= count_next_s;
          wr_done_r      <= 1'b1;
          req_ready_r    <= 1'b1;
          state_r        <= S_IDLE;
        end
        default: begin
          state_r     <= S_INIT;
          init_addr_r <= ADDR_ZERO;
          init_x_r    <= 5'd0;
          init_y_r    <= 5'd0;
          req_ready_r <= 1'b0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_r;
  assign rd_valid     = rd_valid_r;
  assign wr_done      = wr_done_r;
  assign init_done    = init_done_r;
  assign rd_data      = rd_data_r;
  assign pellet_count = pellet_count_r;
  assign all_eaten    = init_done_r && (pellet_count_r == 10'd0);

endmodule

// File: doc/map_tile_server.md
MAP_TILE_SERVER -- requirements
Module: map_tile_server

Interface
REQ-001 SHALL have parameter MAP_W, default 21, map width in tiles (max 32).
REQ-002 SHALL have parameter MAP_H, default 21, map height in tiles (max 32).
REQ-003 SHALL have port clock  input  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  requester presents a tile access.
REQ-006 SHALL have port req_ready  output  1  server can accept a request this cycle.
REQ-007 SHALL have port readwrite  input  1  0 = read, 1 = write.
REQ-008 SHALL have port map_x  input  5  tile column.
REQ-009 SHALL have port map_y  input  5  tile row.
REQ-010 SHALL have port wr_data  input  3  sprite code to write.
REQ-011 SHALL have port rd_data  output  3  sprite code returned for a read.
REQ-012 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-013 SHALL have port wr_done  output  1  one-cycle pulse, write retired.
REQ-014 SHALL have port init_done  output  1  map initialisation complete.
REQ-015 SHALL have port pellet_count  output  10  tiles currently holding 3'b001 or 3'b010.
REQ-016 SHALL have port all_eaten  output  1  init_done and pellet_count == 0.

Function
REQ-017 Sprite codes SHALL be: 3'b000 empty, 3'b001 big blob, 3'b010 small dot, 3'b011 wall; other codes stored as given, treated as non-pellet.
REQ-018 Storage SHALL be MAP_W*MAP_H x 3-bit synchronous RAM, address = map_y*MAP_W + map_x.
REQ-019 FSM states SHALL be S_INIT, S_IDLE, S_READ, S_WR_CHECK, S_WR_COMMIT.
REQ-020 S_INIT SHALL write one tile per cycle, address 0 upward: border tiles 3'b011; (1,1),(MAP_W-2,1),(1,MAP_H-2),(MAP_W-2,MAP_H-2) 3'b001; all others 3'b010; after last address, enter S_IDLE and set init_done.
REQ-021 S_INIT SHALL take exactly MAP_W*MAP_H cycles; pellet_count SHALL then equal MAP_W*MAP_H-(2*MAP_W+2*MAP_H-4) (361 at defaults).
REQ-022 req_ready SHALL be high only in S_IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-023 Accepted read: S_IDLE->S_READ; rd_valid high with rd_data for exactly one cycle, starting at the second rising edge after the accepting edge; return to S_IDLE with req_ready high in that same cycle.
REQ-024 Accepted write: S_IDLE->S_WR_CHECK (fetch old code)->S_WR_COMMIT (store wr_data, update pellet_count, wr_done pulse)->S_IDLE; req_ready high again two edges after acceptance.
REQ-025 map_x, map_y, readwrite, wr_data SHALL be captured at acceptance; later input changes SHALL not affect the transaction.
REQ-026 Out-of-range access (map_x >= MAP_W or map_y >= MAP_H): read SHALL return 3'b011 with normal latency; write SHALL not modify RAM or count but SHALL still pulse wr_done.
REQ-027 Writes to a tile whose stored code is 3'b011 SHALL be ignored (walls immutable), wr_done still pulses.
REQ-028 pellet_count: old pellet, new non-pellet -> decrement; old non-pellet, new pellet -> increment; otherwise unchanged; saturate at 0 and at 1023.
REQ-029 all_eaten SHALL be combinational from init_done and pellet_count.
REQ-030 rd_valid and wr_done SHALL never be high simultaneously; rd_data SHALL hold its last value when rd_valid low.

Reset
REQ-031 reset SHALL force S_INIT, init address 0, req_ready 0, rd_valid 0, wr_done 0, init_done 0, pellet_count 0, rd_data 3'b000, on the next edge.
REQ-032 reset asserted mid-transaction or mid-init SHALL abort it without any rd_valid/wr_done pulse and restart full initialisation.
REQ-033 Requests during S_INIT SHALL be ignored (req_ready low), never queued.

Verification
REQ-034 Reset 1 cycle, release -> init_done rises after exactly 441 cycles, pellet_count=361, all_eaten=0.
REQ-035 Read (0,0), (1,1), (5,5) -> rd_data 3'b011, 3'b001, 3'b010, each rd_valid 2 edges after acceptance, back-to-back every 2 cycles.
REQ-036 Write 3'b000 to (5,5) then read (5,5) -> wr_done after 2 edges, pellet_count=360, read returns 3'b000; rewrite 3'b000 -> count stays 360.
REQ-037 Write 3'b000 to (0,3) and to (25,2) -> wr_done pulses, RAM unchanged, count unchanged; read (25,2) returns 3'b011.
REQ-038 Write 3'b000 to all 361 pellet tiles -> pellet_count=0, all_eaten=1; write 3'b010 to (5,5) -> count=1, all_eaten=0.
REQ-039 Assert reset during S_WR_CHECK and at init address 200 -> no wr_done, init restarts at 0, completes 441 cycles later, count=361.
